// File: rtl/aes_pipe_sched_if.sv
// Purpose : bundles the requester, response and core-side signals of aes_pipe_sched.
// Latency : n/a (wiring only); slave = scheduler view, master = requester/core view.
// Backpr. : reqN_ready is the only back-pressure; responses cannot be stalled.
interface aes_pipe_sched_if #(
    parameter int ID_W  = 4,
    parameter int CNT_W = 5
);
    logic             flush;
    logic             req0_valid;
    logic             req0_ready;
    logic [127:0]     req0_state;
    logic [127:0]     req0_key;
    logic [ID_W-1:0]  req0_id;
    logic             req1_valid;
    logic             req1_ready;
    logic [127:0]     req1_state;
    logic [127:0]     req1_key;
    logic [ID_W-1:0]  req1_id;
    logic             rsp0_valid;
    logic [127:0]     rsp0_data;
    logic [ID_W-1:0]  rsp0_id;
    logic             rsp1_valid;
    logic [127:0]     rsp1_data;
    logic [ID_W-1:0]  rsp1_id;
    logic [127:0]     core_state;
    logic [127:0]     core_key;
    logic [127:0]     core_out;
    logic             busy;
    logic [CNT_W-1:0] inflight;

    modport slave (
        input  flush,
        input  req0_valid, req0_state, req0_key, req0_id,
        input  req1_valid, req1_state, req1_key, req1_id,
        input  core_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_id,
        output rsp1_valid, rsp1_data, rsp1_id,
        output core_state, core_key, busy, inflight
    );

    modport master (
        output flush,
        output req0_valid, req0_state, req0_key, req0_id,
        output req1_valid, req1_state, req1_key, req1_id,
        output core_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_id,
        input  rsp1_valid, rsp1_data, rsp1_id,
        input  core_state, core_key, busy, inflight
    );
endinterface

// File: rtl/aes_pipe_sched.sv
// Purpose : shares one pipelined AES-128 core between two requesters (round-robin),
//           tagging each block with owner/ID and steering ciphertexts back.
// Latency : accept cycle c -> rspX_valid in cycle c+AES_LAT+2; one block per cycle.
// Backpr. : reqN_ready is combinational grant & ~flush & ~rst; responses never stall.
// Ports   : clk, rst (async, active-high); bus = aes_pipe_sched_if.slave
//           (requests, responses, registered core inputs, core_out, busy, inflight).
// Option  : `define AES_SCHED_FIXED_PRIO_EN -> requester 0 always wins (port 1 may starve).
module aes_pipe_sched #(
    parameter int AES_LAT = 21,
    parameter int ID_W    = 4,
    parameter int CNT_W   = 5   // 2**CNT_W must exceed AES_LAT+1
) (
    input  logic            clk,
    input  logic            rst,
    aes_pipe_sched_if.slave bus
);
    // Tag stages 0..AES_LAT track the block while the core works on it; rsp_q
    // holds the tag for the cycle its ciphertext is on core_out.
    localparam int NSTG = AES_LAT + 1;

    typedef struct packed {
        logic            vld;
        logic            owner;
        logic [ID_W-1:0] id;
    } tag_t;

    logic             last_gnt_q, last_gnt_d;
    logic             gnt0, gnt1;
    logic             acc0, acc1, accept;
    logic [127:0]     core_state_q, core_state_d;
    logic [127:0]     core_key_q, core_key_d;
    tag_t             tag_q [NSTG];
    tag_t             tag0_d;
    tag_t             rsp_q;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    // Arbitration: last_gnt_q == 1 means requester 1 won last, so 0 goes next.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef AES_SCHED_FIXED_PRIO_EN
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid & ~bus.req0_valid;
`else
        if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = last_gnt_q;
            gnt1 = ~last_gnt_q;
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
`endif
    end

    assign acc0   = gnt0 & ~bus.flush & ~rst;
    assign acc1   = gnt1 & ~bus.flush & ~rst;
    assign accept = acc0 | acc1;

    always_comb begin
        last_gnt_d   = last_gnt_q;
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        tag0_d       = '0;
        inflight_d   = inflight_q;
        if (accept) begin
`ifndef AES_SCHED_FIXED_PRIO_EN
            last_gnt_d = acc1;
`endif
            core_state_d = acc1 ? bus.req1_state : bus.req0_state;
            core_key_d   = acc1 ? bus.req1_key   : bus.req0_key;
            tag0_d.vld   = 1'b1;
            tag0_d.owner = acc1;
            tag0_d.id    = acc1 ? bus.req1_id : bus.req0_id;
        end
        // A tag leaving the last stage and a new accept in the same cycle cancel.
        if (bus.flush) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(tag_q[NSTG-1].vld);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q   <= 1'b1;
            core_state_q <= '0;
            core_key_q   <= '0;
            inflight_q   <= '0;
            rsp_q        <= '0;
            for (int i = 0; i < NSTG; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_gnt_q   <= last_gnt_d;
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            inflight_q   <= inflight_d;
            // Flush only kills the tags; the core keeps computing, but its
            // output for those blocks is never flagged valid.
            if (bus.flush) begin
                rsp_q <= '0;
                for (int i = 0; i < NSTG; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                rsp_q    <= tag_q[NSTG-1];
                tag_q[0] <= tag0_d;
                for (int i = 1; i < NSTG; i++) begin
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.core_state = core_state_q;
    assign bus.core_key   = core_key_q;
    assign bus.rsp0_valid = rsp_q.vld & ~rsp_q.owner;
    assign bus.rsp1_valid = rsp_q.vld &  rsp_q.owner;
    assign bus.rsp0_id    = rsp_q.id;
    assign bus.rsp1_id    = rsp_q.id;
    assign bus.rsp0_data  = bus.core_out;
    assign bus.rsp1_data  = bus.core_out;
    assign bus.inflight   = inflight_q;
    assign bus.busy       = (inflight_q != '0) | rsp_q.vld | accept;
endmodule

// File: tb/tb_aes_pipe_sched.sv
// Purpose : randomized + directed bench for aes_pipe_sched with a software AES core
//           and a transaction-level scoreboard checked every negedge.
// Latency : n/a.   Backpr.: requesters hold their block until ready.
module tb_aes_pipe_sched;
    localparam int AES_LAT = 21;
    localparam int ID_W    = 4;
    localparam int CNT_W   = 5;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_pipe_sched_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus ();
    aes_pipe_sched #(.AES_LAT(AES_LAT), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // ---------------- software AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = b;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, t0, a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) begin
            s[k] = pt[127-8*k -: 8];
            w[k] = key[127-8*k -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[t0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[k];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[16*r+k];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // Core: no reset, no valid; samples its inputs every edge, result AES_LAT cycles later.
    logic [127:0] core_pipe [AES_LAT+1];
    always @(posedge clk) begin
        for (int i = AES_LAT; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= aes_enc(bus.core_state, bus.core_key);
    end
    assign bus.core_out = core_pipe[AES_LAT];

    // ---------------- transaction-level scoreboard ----------------
    typedef struct {
        int              due;   // cycle in which the response must be visible
        logic            owner;
        logic [ID_W-1:0] id;
        logic [127:0]    data;
    } exp_t;
    exp_t mq[$];
    int   cyc    = 0;
    logic m_last = 1'b1;

    initial begin
        exp_t pend, er;
        logic pend_acc, pend_flush, e0, e1, found;
        int ninf;
        forever begin
            @(negedge clk);
            pend_acc = 1'b0; pend_flush = 1'b0;
            if (rst) begin
                chk("rst_ready0", 128'(bus.req0_ready), 128'(0));
                chk("rst_ready1", 128'(bus.req1_ready), 128'(0));
                chk("rst_rsp0_valid", 128'(bus.rsp0_valid), 128'(0));
                chk("rst_rsp1_valid", 128'(bus.rsp1_valid), 128'(0));
                chk("rst_busy", 128'(bus.busy), 128'(0));
                chk("rst_inflight", 128'(bus.inflight), 128'(0));
            end else begin
                e0 = 1'b0; e1 = 1'b0;
                if (!bus.flush) begin
`ifdef AES_SCHED_FIXED_PRIO_EN
                    if (bus.req0_valid) e0 = 1'b1;
                    else if (bus.req1_valid) e1 = 1'b1;
`else
                    if (bus.req0_valid && bus.req1_valid) begin
                        if (m_last) e0 = 1'b1; else e1 = 1'b1;
                    end else begin
                        e0 = bus.req0_valid; e1 = bus.req1_valid;
                    end
`endif
                end
                found = 1'b0; ninf = 0;
                foreach (mq[i]) begin
                    if (mq[i].due == cyc) begin found = 1'b1; er = mq[i]; end
                    else if (mq[i].due > cyc) ninf++;
                end
                chk("ready0", 128'(bus.req0_ready), 128'(e0));
                chk("ready1", 128'(bus.req1_ready), 128'(e1));
                chk("rsp0_valid", 128'(bus.rsp0_valid), 128'(found && !er.owner));
                chk("rsp1_valid", 128'(bus.rsp1_valid), 128'(found && er.owner));
                if (found) begin
                    chk("rsp_data", er.owner ? bus.rsp1_data : bus.rsp0_data, er.data);
                    chk("rsp_id", 128'(er.owner ? bus.rsp1_id : bus.rsp0_id), 128'(er.id));
                end
                chk("inflight", 128'(bus.inflight), 128'(ninf));
                chk("busy", 128'(bus.busy), 128'(ninf > 0 || found || e0 || e1));
                chk("inflight_bound", 128'(bus.inflight <= AES_LAT + 1), 128'(1));
                chk("rsp_onehot", 128'(bus.rsp0_valid & bus.rsp1_valid), 128'(0));
                pend_flush = bus.flush;
                if (e0 || e1) begin
                    pend_acc   = 1'b1;
                    pend.due   = cyc + AES_LAT + 2;
                    pend.owner = e1;
                    pend.id    = e1 ? bus.req1_id : bus.req0_id;
                    pend.data  = e1 ? aes_enc(bus.req1_state, bus.req1_key)
                                    : aes_enc(bus.req0_state, bus.req0_key);
                end
            end
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_last = 1'b1;
            end else begin
                if (pend_flush) mq.delete();
                if (pend_acc) begin
                    mq.push_back(pend);
                    m_last = pend.owner;
                end
                while (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
                cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic             r0, r1, s_rsp0, s_rsp1, s_busy, saw1;
    logic [CNT_W-1:0] inf_s, peak;
    logic [ID_W-1:0]  s_id0, s_id1, got_id;
    logic [127:0]     s_data0, got_data;
    logic [7:0]       gseq;
    logic [19:0]      idseq;
    int               got_lat, nacc, nrsp, first_k, last_k;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic new0();
        bus.req0_state = rand128(); bus.req0_key = rand128();
        bus.req0_id = ID_W'($urandom_range(0, 15));
    endtask

    task automatic new1();
        bus.req1_state = rand128(); bus.req1_key = rand128();
        bus.req1_id = ID_W'($urandom_range(0, 15));
    endtask

    // Inputs are driven at posedge+1; outputs sampled at posedge+4.
    task automatic tick();
        #3;
        r0 = bus.req0_ready; r1 = bus.req1_ready; inf_s = bus.inflight;
        s_rsp0 = bus.rsp0_valid; s_rsp1 = bus.rsp1_valid; s_busy = bus.busy;
        s_id0 = bus.rsp0_id; s_id1 = bus.rsp1_id; s_data0 = bus.rsp0_data;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        build_sbox();
        rst = 1'b1;
        bus.flush = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        new0(); new1();
        chk("aes_model_fips", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);
        @(posedge clk); #1;

        // Reset state, with both requesters asking.
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        tick();
        chk("reset_ready0", 128'(r0), 128'(0));
        chk("reset_ready1", 128'(r1), 128'(0));
        chk("reset_inflight", 128'(inf_s), 128'(0));
        chk("reset_busy", 128'(s_busy), 128'(0));
        chk("reset_core_state", bus.core_state, 128'(0));
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; rst = 1'b0;
        tick();

        // FIPS-197 vector through requester 0.
        bus.req0_valid = 1'b1; bus.req0_state = FIPS_PT; bus.req0_key = FIPS_KEY; bus.req0_id = 4'd3;
        tick();
        chk("fips_accept", 128'(r0), 128'(1));
        bus.req0_valid = 1'b0;
        got_lat = -1; saw1 = 1'b0; got_data = '0; got_id = '0;
        for (int k = 1; k <= AES_LAT + 10; k++) begin
            tick();
            if (s_rsp0 && got_lat < 0) begin got_lat = k; got_data = s_data0; got_id = s_id0; end
            if (s_rsp1) saw1 = 1'b1;
        end
        chk("fips_latency", 128'(got_lat), 128'(AES_LAT + 2));
        chk("fips_data", got_data, FIPS_CT);
        chk("fips_id", 128'(got_id), 128'(3));
        chk("fips_no_rsp1", 128'(saw1), 128'(0));

        // Both requesters valid for 8 cycles straight after reset.
        do_reset();
        gseq = '0; nacc = 0; peak = '0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; new0(); new1();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (inf_s > peak) peak = inf_s;
            gseq[k] = r1;
            if (r0 || r1) nacc++;
            if (r0) new0();
            if (r1) new1();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        for (int k = 0; k < AES_LAT + 8; k++) begin
            tick();
            if (inf_s > peak) peak = inf_s;
        end
`ifdef AES_SCHED_FIXED_PRIO_EN
        chk("both_valid_grants", 128'(gseq), 128'(8'h00));
`else
        chk("both_valid_grants", 128'(gseq), 128'(8'haa));
`endif
        chk("both_valid_accepts", 128'(nacc), 128'(8));
        chk("both_valid_peak_inflight", 128'(peak), 128'(8));

        // Requester 1 alone: five back-to-back blocks, ids 0..4.
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            bus.req1_valid = 1'b1; new1(); bus.req1_id = ID_W'(k);
            tick();
            if (r1) nacc++;
        end
        bus.req1_valid = 1'b0;
        nrsp = 0; idseq = '0; first_k = -1; last_k = -1;
        for (int k = 0; k < AES_LAT + 10; k++) begin
            tick();
            if (s_rsp1) begin
                if (nrsp < 5) idseq[4*nrsp +: 4] = s_id1;
                if (first_k < 0) first_k = k;
                last_k = k;
                nrsp++;
            end
        end
        chk("req1_accepts", 128'(nacc), 128'(5));
        chk("req1_rsp_count", 128'(nrsp), 128'(5));
        chk("req1_rsp_contiguous", 128'(last_k - first_k), 128'(4));
        chk("req1_rsp_ids", 128'(idseq), 128'(20'h43210));

        // Three blocks, one flush cycle, one more block.
        for (int k = 0; k < 3; k++) begin
            bus.req0_valid = 1'b1; new0();
            tick();
        end
        new0();
        bus.flush = 1'b1;
        tick();
        chk("flush_blocks_ready", 128'(r0), 128'(0));
        bus.flush = 1'b0;
        tick();
        chk("inflight_after_flush", 128'(inf_s), 128'(0));
        chk("post_flush_accept", 128'(r0), 128'(1));
        bus.req0_valid = 1'b0;
        tick();
        chk("inflight_post_flush_block", 128'(inf_s), 128'(1));
        nrsp = 0;
        for (int k = 0; k < AES_LAT + 10; k++) begin
            tick();
            if (s_rsp0 || s_rsp1) nrsp++;
        end
        chk("flush_rsp_count", 128'(nrsp), 128'(1));

        // Asynchronous reset with 10 blocks in flight.
        for (int k = 0; k < 10; k++) begin
            bus.req0_valid = 1'b1; new0();
            tick();
        end
        #2; rst = 1'b1; #1;
        chk("arst_ready0", 128'(bus.req0_ready), 128'(0));
        chk("arst_rsp0_valid", 128'(bus.rsp0_valid), 128'(0));
        chk("arst_rsp1_valid", 128'(bus.rsp1_valid), 128'(0));
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_inflight", 128'(bus.inflight), 128'(0));
        chk("arst_core_state", bus.core_state, 128'(0));
        chk("arst_core_key", bus.core_key, 128'(0));
        @(posedge clk); #1; @(posedge clk); #1;
        bus.req0_valid = 1'b0; rst = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 2 * AES_LAT; k++) begin
            tick();
            if (s_rsp0 || s_rsp1) nrsp++;
        end
        chk("post_reset_quiet", 128'(nrsp), 128'(0));

        // Random traffic with occasional flushes.
        r0 = 1'b0; r1 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!bus.req0_valid || r0) begin
                bus.req0_valid = ($urandom_range(0, 99) < 60); new0();
            end
            if (!bus.req1_valid || r1) begin
                bus.req1_valid = ($urandom_range(0, 99) < 60); new1();
            end
            bus.flush = ($urandom_range(0, 99) < 3);
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.flush = 1'b0;
        for (int k = 0; k < AES_LAT + 10; k++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
